etapa_mem: RTL and testbench

//  Memory-access stage of the 5-stage pipeline, between EX/MEM and MEM/WB registers.

---
 rtl/etapa_mem.sv | 125 ++++++++++++
 tb/tb_etapa_mem.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etapa_mem.sv
// Memory-access pipeline stage: drives a req/ack data memory and stalls upstream until done.
// Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module etapa_mem #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memread_mem,
  input  logic              memwrite_mem,
  input  logic [ADDR_W-1:0] alu_result_mem,
  input  logic [DATA_W-1:0] write_data_mem,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] read_data_mem,
  output logic              stall_mem,
  output logic              mem_timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_op;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^TIMEOUT_CYCLES;
`endif

  assign w_op = memread_mem | memwrite_mem;

  // DONE keeps the still-held EX/MEM instruction from retriggering an access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
`ifdef MEM_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_op) begin
            r_req   <= 1'b1;
            r_we    <= memwrite_mem;
            r_addr  <= {alu_result_mem[ADDR_W-1:2], 2'b00};
            r_wdata <= write_data_mem;
            r_state <= S_ACCESS;
`ifdef MEM_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_ACCESS: begin
          if (dmem_ack) begin
            r_req   <= 1'b0;
            if (!r_we) begin
              r_rdata <= dmem_rdata;
            end
            r_state <= S_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_req     <= 1'b0;
            r_rdata   <= DATA_W'(32'hDEAD_BEEF);
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        S_DONE: begin
`ifdef MEM_TIMEOUT_EN
          r_timeout <= 1'b0;
`endif
          r_state <= S_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dmem_req      = r_req;
  assign dmem_we       = r_we;
  assign dmem_addr     = r_addr;
  assign dmem_wdata    = r_wdata;
  assign read_data_mem = r_rdata;

  // Gated by rst_n so the stall releases the instant reset asserts
  assign stall_mem = rst_n & (((r_state == S_IDLE) & w_op) | (r_state == S_ACCESS));

`ifdef MEM_TIMEOUT_EN
  assign mem_timeout = r_timeout;
`else
  assign mem_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_etapa_mem.sv
// Scoreboard bench for etapa_mem: randomized pipeline stimulus, memory responder, reference model.
module tb_etapa_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memread_mem, memwrite_mem;
  logic [31:0] alu_result_mem, write_data_mem;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] read_data_mem;
  logic        stall_mem, mem_timeout;

  always #5 clk = ~clk;

  etapa_mem dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .memread_mem   (memread_mem),
    .memwrite_mem  (memwrite_mem),
    .alu_result_mem(alu_result_mem),
    .write_data_mem(write_data_mem),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .read_data_mem (read_data_mem),
    .stall_mem     (stall_mem),
    .mem_timeout   (mem_timeout)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem[int unsigned];
  logic [31:0] dmem[int unsigned];
  logic [31:0] last_load = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          hold_ack = 1'b0;
  bit          scramble = 1'b0;
  int          force_target = -1;
  int          resp_target = 0;
  int          resp_cnt = 0;
  bit          resp_active = 1'b0;

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks after a chosen number of req cycles, plus stray acks while idle
  initial begin
    int unsigned w;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        resp_active = 1'b0;
        dmem_ack    = 1'b0;
      end else if (dmem_req) begin
        if (!resp_active) begin
          resp_active = 1'b1;
          resp_cnt    = 0;
          resp_target = hold_ack ? 1000000 :
                        (force_target >= 0 ? force_target : int'($urandom_range(0, 3)));
        end
        if (resp_cnt == resp_target) begin
          dmem_ack = 1'b1;
          w = dmem_addr >> 2;
          if (dmem_we) begin
            dmem[w]    = dmem_wdata;
            dmem_rdata = $urandom;
          end else begin
            dmem_rdata = dmem.exists(w) ? dmem[w] : init_word(w);
          end
          resp_active = 1'b0;
        end else begin
          dmem_ack = 1'b0;
          resp_cnt++;
        end
      end else begin
        resp_active = 1'b0;
        dmem_ack    = ($urandom_range(0, 3) == 0);
        dmem_rdata  = $urandom;
      end
    end
  end

  // Monitor: on each completed handshake pop the expectation, then check the DONE cycle
  initial begin
    exp_t cur;
    int   req_cnt = 0;
    int   stall_cnt = 0;
    bit   done_pend = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        req_cnt   = 0;
        stall_cnt = 0;
        done_pend = 1'b0;
      end else if (done_pend) begin
        done_pend = 1'b0;
        chk("read_data_mem", read_data_mem, cur.rd);
        chk("done_stall_req", {30'b0, stall_mem, dmem_req}, 32'h0);
        chk("done_timeout", 32'(mem_timeout), 32'h0);
      end else begin
        if (stall_mem) stall_cnt++;
        if (dmem_req)  req_cnt++;
        if (dmem_req && dmem_ack) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_access", dmem_addr, 32'hFFFF_FFFF);
          end else begin
            cur = exp_q.pop_front();
            chk("dmem_we", 32'(dmem_we), 32'(cur.we));
            chk("dmem_addr", dmem_addr, cur.addr);
            if (cur.we) chk("dmem_wdata", dmem_wdata, cur.wdata);
            chk("req_cycles", 32'(req_cnt), 32'(resp_target + 1));
            chk("stall_cycles", 32'(stall_cnt), 32'(req_cnt + 1));
            done_pend = 1'b1;
          end
          req_cnt   = 0;
          stall_cnt = 0;
        end
      end
    end
  end

  // Present one instruction (called #1 after a rising edge) and hold it until the stage advances
  task automatic run_instr(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int unsigned w;
    int          cyc;
    logic        st;
    w = a >> 2;
    if (rd | wr) begin
      e.we    = wr;
      e.addr  = a & 32'hFFFF_FFFC;
      e.wdata = wd;
      if (wr) begin
        ref_mem[w] = wd;
      end else begin
        last_load = ref_mem.exists(w) ? ref_mem[w] : init_word(w);
      end
      e.rd = last_load;
      exp_q.push_back(e);
    end
    memread_mem    = rd;
    memwrite_mem   = wr;
    alu_result_mem = a;
    write_data_mem = wd;
    if (!(rd | wr)) begin
      #1;
      chk("alu_no_stall", {30'b0, stall_mem, dmem_req}, 32'h0);
    end
    cyc = 0;
    forever begin
      @(negedge clk);
      st = stall_mem;
      @(posedge clk);
      #1;
      cyc++;
      if (!st) break;
      if (cyc > 60) begin
        chk("advance_timeout", 32'(cyc), 32'd60);
        break;
      end
      if (scramble && $urandom_range(0, 1) == 1) begin
        memread_mem    = 1'($urandom);
        memwrite_mem   = 1'($urandom);
        alu_result_mem = $urandom;
        write_data_mem = $urandom;
      end
    end
  endtask

  initial begin
    int kind;
    int nreq;
    int bad;
    logic [31:0] a;
    memread_mem    = 1'b0;
    memwrite_mem   = 1'b0;
    alu_result_mem = 32'h0;
    write_data_mem = 32'h0;
    #3;
    chk("rst_req_we", {30'b0, dmem_req, dmem_we}, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_rdata", read_data_mem, 32'h0);
    chk("rst_stall_timeout", {30'b0, stall_mem, mem_timeout}, 32'h0);
    #20;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    dmem[4] = 32'hCAFE_F00D;
    ref_mem[4] = 32'hCAFE_F00D;
    force_target = 0;
    run_instr(1'b1, 1'b0, 32'h10, $urandom);
    force_target = 2;
    run_instr(1'b0, 1'b1, 32'h24, 32'h1234_5678);
    force_target = -1;
    repeat (10) run_instr(1'b0, 1'b0, $urandom, $urandom);
    dmem[12] = 32'h1111_1111;
    ref_mem[12] = 32'h1111_1111;
    dmem[13] = 32'h2222_2222;
    ref_mem[13] = 32'h2222_2222;
    force_target = 0;
    run_instr(1'b1, 1'b0, 32'h30, $urandom);
    run_instr(1'b1, 1'b0, 32'h36, $urandom);
    force_target = -1;

    scramble = 1'b1;
    repeat (80) begin
      kind = int'($urandom_range(0, 3));
      a = $urandom & 32'h3000_003F;
      run_instr(kind == 1 || kind == 3, kind >= 2, a, $urandom);
    end
    scramble = 1'b0;
    run_instr(1'b0, 1'b0, 32'h0, 32'h0);

    // Reset in the middle of an access
    hold_ack = 1'b1;
    memread_mem = 1'b1;
    memwrite_mem = 1'b0;
    alu_result_mem = 32'h44;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_req", 32'(dmem_req), 32'h1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_req_stall", {30'b0, dmem_req, stall_mem}, 32'h0);
    chk("midrst_rdata", read_data_mem, 32'h0);
    chk("midrst_addr", dmem_addr, 32'h0);
    memread_mem = 1'b0;
    hold_ack = 1'b0;
    last_load = 32'h0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_instr(1'b1, 1'b0, 32'h44, $urandom);
    run_instr(1'b0, 1'b0, 32'h0, 32'h0);

    // Access that is never acknowledged
    hold_ack = 1'b1;
    memread_mem = 1'b1;
    alu_result_mem = 32'h48;
    @(posedge clk);
    #1;
`ifdef MEM_TIMEOUT_EN
    nreq = 0;
    while (dmem_req && nreq < 40) begin
      nreq++;
      @(posedge clk);
      #1;
    end
    chk("timeout_req_cycles", 32'(nreq), 32'd16);
    chk("timeout_pulse", 32'(mem_timeout), 32'h1);
    chk("timeout_rdata", read_data_mem, 32'hDEAD_BEEF);
    chk("timeout_done_stall", 32'(stall_mem), 32'h0);
    memread_mem = 1'b0;
    @(posedge clk);
    #1;
    chk("timeout_pulse_end", 32'(mem_timeout), 32'h0);
`else
    bad = 0;
    repeat (100) begin
      if (!(stall_mem && dmem_req && !mem_timeout)) bad++;
      @(posedge clk);
      #1;
    end
    chk("noack_stall_held", 32'(bad), 32'h0);
`endif
    memread_mem = 1'b0;
    hold_ack = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    last_load = 32'h0;
    @(posedge clk);
    #1;
    run_instr(1'b1, 1'b0, 32'h10, $urandom);
    run_instr(1'b0, 1'b0, 32'h0, 32'h0);

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
